// File: rtl/minterm_pkg.sv
// Shared types and helpers for the minterm sweeper: state encoding,
// table-depth helper and the saturating counter increment.
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_N   = 3;
  localparam int unsigned TABLE_DEPTH = 1 << DEFAULT_N;

  function automatic int unsigned table_depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Increment that sticks at the all-ones value of a counter 'width' bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/minterm_sweeper_term_lookup.sv
// Combinational truth-table lookup: SoP and PoS values of both programmed
// functions at one input combination.
module term_lookup
  import minterm_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]              idx,
  input  logic [table_depth(N)-1:0] sop_mask,
  input  logic [table_depth(N)-1:0] pos_mask,
  output logic                      sop,
  output logic                      pos,
  output logic                      mismatch
);

  // A present maxterm forces the PoS product to 0 at that index.
  assign sop      = sop_mask[idx];
  assign pos      = ~pos_mask[idx];
  assign mismatch = sop ^ pos;

endmodule

// File: rtl/minterm_sweeper.sv
// Sweeps all 2^N input combinations through programmable SoP/PoS masks,
// streams both values per beat and counts disagreements.
//
//   state | meaning
//   IDLE  | waiting for start; masks may be loaded
//   SWEEP | one index issued per cycle, beats registered one cycle later
//   DONE  | single-shot sweep finished; err_count/equiv held
module minterm_sweeper
  import minterm_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [table_depth(N)-1:0] sop_mask,
  input  logic [table_depth(N)-1:0] pos_mask,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  output logic                      busy,
  output logic                      out_valid,
  output logic [N-1:0]              out_idx,
  output logic                      sop_out,
  output logic                      pos_out,
  output logic                      mismatch,
  output logic                      last,
  output logic [CNT_W-1:0]          err_count,
  output logic                      done,
  output logic                      equiv
);

  localparam int unsigned   DEPTH   = table_depth(N);
  localparam logic [N-1:0]  IDX_MAX = N'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DEPTH-1:0]   sop_q, pos_q;
  logic               loop_q;
  logic               load_en, start_en, beat_en;
  logic               lk_sop, lk_pos, lk_mis;

  term_lookup #(.N(N)) u_lookup (
    .idx      (idx_q),
    .sop_mask (sop_q),
    .pos_mask (pos_q),
    .sop      (lk_sop),
    .pos      (lk_pos),
    .mismatch (lk_mis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load_en  = 1'b0;
    start_en = 1'b0;
    beat_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        load_en = load;
        if (start) begin
          state_d  = SWEEP;
          start_en = 1'b1;
          idx_d    = '0;
        end
      end
      SWEEP: begin
        // stop drops the beat that would have been registered at this edge
        if (stop) begin
          state_d = IDLE;
        end else begin
          beat_en = 1'b1;
          if (idx_q == IDX_MAX) begin
            idx_d = '0;
            if (!loop_q) state_d = DONE;
          end else begin
            idx_d = idx_q + N'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      sop_q     <= '0;
      pos_q     <= '0;
      loop_q    <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      sop_out   <= 1'b0;
      pos_out   <= 1'b0;
      mismatch  <= 1'b0;
      last      <= 1'b0;
      err_count <= '0;
    end else begin
      idx_q     <= idx_d;
      out_valid <= beat_en;
      if (load_en) begin
        sop_q <= sop_mask;
        pos_q <= pos_mask;
      end
      if (start_en) begin
        loop_q    <= loop;
        err_count <= '0;
      end
      if (beat_en) begin
        out_idx  <= idx_q;
        sop_out  <= lk_sop;
        pos_out  <= lk_pos;
        mismatch <= lk_mis;
        last     <= (idx_q == IDX_MAX);
        if (lk_mis) err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
      end
    end
  end

  assign busy  = (state_q == SWEEP);
  assign done  = (state_q == DONE);
  assign equiv = done && (err_count == '0);

endmodule

// File: tb/tb_minterm_sweeper.sv
// Scoreboard bench for minterm_sweeper: stimulus pushes expected beats,
// a negedge monitor pops and compares every valid beat.
module tb_minterm_sweeper;

  typedef struct packed {
    logic [2:0] idx;
    logic       sop;
    logic       pos;
    logic       mis;
    logic       last;
  } beat_t;

  logic       clk, reset, load, start, stop, loop;
  logic [7:0] sop_mask, pos_mask;
  logic       busy, out_valid, sop_out, pos_out, mismatch, last, done, equiv;
  logic [2:0] out_idx;
  logic [7:0] err_count;

  logic       busy2, out_valid2, sop_out2, pos_out2, mismatch2, last2, done2, equiv2;
  logic [2:0] out_idx2;
  logic [1:0] err_count2;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  beat_t sb[$];

  minterm_sweeper #(.N(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .sop_mask(sop_mask), .pos_mask(pos_mask),
    .start(start), .stop(stop), .loop(loop), .busy(busy), .out_valid(out_valid),
    .out_idx(out_idx), .sop_out(sop_out), .pos_out(pos_out), .mismatch(mismatch),
    .last(last), .err_count(err_count), .done(done), .equiv(equiv)
  );

  minterm_sweeper #(.N(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .load(load), .sop_mask(sop_mask), .pos_mask(pos_mask),
    .start(start), .stop(stop), .loop(loop), .busy(busy2), .out_valid(out_valid2),
    .out_idx(out_idx2), .sop_out(sop_out2), .pos_out(pos_out2), .mismatch(mismatch2),
    .last(last2), .err_count(err_count2), .done(done2), .equiv(equiv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {29'd0, out_idx}, 32'hFFFF_FFFF);
      end else begin
        beat_t exp_b;
        exp_b = sb.pop_front();
        chk("beat", {25'd0, out_idx, sop_out, pos_out, mismatch, last}, {25'd0, exp_b});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_sweep(input logic [7:0] s, input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.idx  = 3'(k);
      b.sop  = s[k];
      b.pos  = ~p[k];
      b.mis  = s[k] ^ ~p[k];
      b.last = (k == 7);
      sb.push_back(b);
    end
  endtask

  task automatic start_sweep(input logic [7:0] s, input logic [7:0] p, input logic lp, input logic ld);
    sop_mask = s;
    pos_mask = p;
    load     = ld;
    loop     = lp;
    start    = 1'b1;
    tick();
    start = 1'b0;
    load  = 1'b0;
    loop  = 1'b0;
  endtask

  task automatic check_finished(input string tag, input int exp_err);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
    chk({tag, "_equiv"}, 32'(equiv), 32'(exp_err == 0));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    tick();
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_hold"}, 32'(done), 32'd1);
    chk({tag, "_err_hold"}, 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    sop_mask = 8'h00; pos_mask = 8'h00;
    tick(); tick();
    chk("rst_outputs", {busy, out_valid, done, equiv, last, mismatch, sop_out, pos_out},
        8'h00);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    reset = 1'b0;
    tick();

    // 1: equivalent SoP/PoS pair
    push_sweep(8'b1101_0101, 8'b0010_1010, 8);
    start_sweep(8'b1101_0101, 8'b0010_1010, 1'b0, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (8) tick();
    check_finished("t1", 0);

    // 2: maxterm 5 dropped, started from DONE
    push_sweep(8'b1101_0101, 8'b0000_1010, 8);
    start_sweep(8'b1101_0101, 8'b0000_1010, 1'b0, 1'b1);
    chk("t2_done_drop", 32'(done), 32'd0);
    chk("t2_err_clr", 32'(err_count), 32'd0);
    repeat (8) tick();
    check_finished("t2", 1);

    // 3: continuous sweep, 5 passes then stop
    for (int pass = 0; pass < 5; pass++) push_sweep(8'b1101_0101, 8'b0000_1010, 8);
    start_sweep(8'b1101_0101, 8'b0000_1010, 1'b1, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_valid", 32'(out_valid), 32'd1);
      if (c % 8 == 0) begin
        chk("t3_err", 32'(err_count), 32'(c / 8));
        chk("t3_err_sat", 32'(err_count2), 32'((c / 8) > 3 ? 3 : (c / 8)));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk("t3_stop_valid", 32'(out_valid), 32'd0);
    chk("t3_stop_err", 32'(err_count), 32'd5);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: stop while index 3 is issued
    push_sweep(8'b0000_0011, 8'b0000_0000, 3);
    start_sweep(8'b0000_0011, 8'b0000_0000, 1'b0, 1'b1);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_err", 32'(err_count), 32'd1);
    tick();
    chk("t4_err_hold", 32'(err_count), 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: load (and start) during SWEEP ignored; load+start from DONE used
    push_sweep(8'b1101_0101, 8'b0010_1010, 8);
    start_sweep(8'b1101_0101, 8'b0010_1010, 1'b0, 1'b1);
    tick();
    sop_mask = 8'h00; pos_mask = 8'h00; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (6) tick();
    check_finished("t5a", 0);
    push_sweep(8'b1000_0001, 8'b0000_0000, 8);
    start_sweep(8'b1000_0001, 8'b0000_0000, 1'b0, 1'b1);
    repeat (8) tick();
    check_finished("t5b", 6);

    // 6: asynchronous reset mid-sweep clears masks too
    push_sweep(8'h0F, 8'h0F, 8);
    start_sweep(8'h0F, 8'h0F, 1'b0, 1'b1);
    repeat (3) tick();
    chk("t6_pre_err", 32'(err_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_flags", {28'd0, busy, out_valid, done, equiv}, 32'd0);
    chk("t6_rst_err", 32'(err_count), 32'd0);
    chk("t6_rst_idx", 32'(out_idx), 32'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    push_sweep(8'h00, 8'h00, 8);
    start_sweep(8'hFF, 8'hFF, 1'b0, 1'b0);
    repeat (8) tick();
    check_finished("t6", 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/minterm_sweeper.md
Name: minterm_sweeper

Overview:
- Sequential successor to the fixed 3-input SoP/PoS evaluators, generalised to N inputs with run-time programmable functions.
- Holds a programmable minterm mask (SoP form) and maxterm mask (PoS form).
- Steps an input index through all 2^N combinations, one per clock, and streams both function values per combination.
- Counts SoP/PoS disagreements and reports whether the two forms are equivalent.
- Used as a self-checking truth-table engine in the guide test benches.

Parameters:
N, 3, number of function inputs (1..8); table depth is 2^N.
CNT_W, 8, width of the mismatch counter (must be >= N+1).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  capture sop_mask/pos_mask
sop_mask  input  2^N  bit i = 1: minterm i present (SoP = 1 at index i)
pos_mask  input  2^N  bit i = 1: maxterm i present (PoS = 0 at index i)
start  input  1  begin a sweep
stop  input  1  abort the sweep
loop  input  1  1 = continuous sweep, 0 = single shot (sampled with start)
busy  output  1  high while in SWEEP
out_valid  output  1  out_* fields valid this cycle
out_idx  output  N  input combination for this beat (MSB = first variable)
sop_out  output  1  SoP value at out_idx
pos_out  output  1  PoS value at out_idx
mismatch  output  1  sop_out ^ pos_out
last  output  1  beat for out_idx = 2^N-1
err_count  output  CNT_W  mismatches counted since start, saturating
done  output  1  high in DONE state
equiv  output  1  valid with done: err_count == 0

Behaviour:
- Reset (async, immediate): state IDLE, both mask registers 0, index 0. All outputs 0, including out_idx and err_count.
- States:
  - IDLE: wait for start.
  - SWEEP: issue one index per cycle.
  - DONE: hold results.
- Masks:
  - load captures both masks at the clock edge, in IDLE or DONE only; ignored in SWEEP.
  - load and start in the same cycle: the new masks are used by that sweep.
- Start: in IDLE or DONE, start at edge E0 gives state SWEEP, index 0, err_count 0, loop latched; done drops.
- Pipeline: one registered stage.
  - Index k is issued at edge Ek.
  - Edge E(k+1) registers out_valid=1, out_idx=k, sop_out=sop_mask[k], pos_out=~pos_mask[k], mismatch and last.
  - err_count is updated at the same edge, so it includes beat k.
- Index wrap, single-shot: issuing 2^N-1 is final. At the edge registering its beat (E(2^N)), the state goes to DONE.
  - done=1 and equiv=(err_count==0) are valid from the same edge as last.
  - out_valid drops the following cycle.
- Index wrap, loop: the index wraps 2^N-1 to 0 with no gap and out_valid stays high. err_count keeps accumulating and saturates at 2^CNT_W-1.
- Stop in SWEEP: at the next edge the state goes to IDLE and out_valid goes to 0 (the in-flight beat is dropped). err_count holds its partial value; done stays 0.
- Stop outside SWEEP is ignored. Start during SWEEP is ignored. Start and stop together in SWEEP: stop wins.
- busy = (state == SWEEP).
- DONE holds err_count and equiv until start or reset.
- Reset mid-sweep: immediate return to the reset values above, masks included.

Decomposition:
- Shared package (minterm_pkg):
  - state encoding: IDLE=2'b00, SWEEP=2'b01, DONE=2'b10
  - sat_inc function for the counter
  - TABLE_DEPTH = 1<<N helper constant
- One natural sub-module: term_lookup.
  - Combinational index into both masks, producing sop/pos/mismatch for a given index.
  - Reusable by the guide test modules.

Test Plan:
1. N=3; load sop_mask=8'b1101_0101 (minterms 0,2,4,6,7) and pos_mask=8'b0010_1010 (maxterms 1,3,5); start, loop=0.
   -> 8 beats, out_idx 0..7, sop_out = pos_out = 1,0,1,0,1,0,1,1; last on idx 7; done=1, err_count=0, equiv=1 at edge E8.
2. Same as 1 but pos_mask=8'b0000_1010 (maxterm 5 dropped).
   -> mismatch=1 only on out_idx=5; err_count=1, equiv=0.
3. loop=1 with masks from 2, run 40 cycles.
   -> out_idx wraps 7 to 0 without a gap; err_count increments once per pass; busy stays 1.
   -> CNT_W=2 variant: err_count saturates at 3.
4. stop asserted while index 3 is issued.
   -> next cycle state IDLE, out_valid=0, done=0; err_count keeps its partial value.
5. load with new masks during SWEEP.
   -> ignored: the sweep output matches the old masks.
   -> load+start in the same cycle from DONE: the new masks are used.
6. reset pulsed asynchronously between edges mid-sweep.
   -> busy, out_valid, done, err_count and out_idx all 0 immediately.
   -> the next start with zero masks gives sop_out=0, pos_out=1 on every beat and err_count=8.
